braille_cell_driver: RTL and testbench

Consumer end of the classifier's `out_valid`/`alpha` result stream. Queues recognised character codes, translates each into a 6-dot Braille pattern, and shifts it serially into an external 8-bit latching shift register (74HC595-style) that drives the solenoid cell. Each pattern is held for a dwell time, then blanked for a gap, before the next character is shown. The block sits beside `cnn_top` under `top` and also mirrors the active pattern onto `o_dots` for board LEDs.

---
 rtl/braille_pkg.sv | 78 +++++++
 rtl/sync_fifo.sv | 56 +++++
 rtl/braille_cell_driver.sv | 192 +++++++++++++++++++
 tb/tb_braille_cell_driver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/braille_pkg.sv
// Shared types and the ASCII-to-Braille lookup used by the cell driver.
package braille_pkg;

    // Serial frame sent to the external latching shift register
    localparam int FRAME_W = 8;
    localparam int DOTS_W  = 6;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DWELL,
        ST_GAP
    } state_t;

    // What the frame currently in the shifter is, so LATCH knows where to go next
    typedef enum logic [1:0] {
        FK_CLEAR,
        FK_CHAR,
        FK_GAP
    } frame_kind_t;

    typedef struct packed {
        logic              valid;
        logic [DOTS_W-1:0] dots;
    } lookup_t;

    // Grade-1 letters; bit i of dots is Braille dot i+1. Non-letters give a blank, invalid cell.
    function automatic lookup_t alpha_to_dots(input logic [7:0] code);
        lookup_t    r;
        logic [4:0] idx;
        r.valid = 1'b0;
        r.dots  = '0;
        idx     = '0;
        if (code >= 8'h41 && code <= 8'h5A) begin
            idx     = 5'(code - 8'h41);
            r.valid = 1'b1;
        end else if (code >= 8'h61 && code <= 8'h7A) begin
            idx     = 5'(code - 8'h61);
            r.valid = 1'b1;
        end
        if (r.valid) begin
            case (idx)
                5'd0:    r.dots = 6'b000001; // a
                5'd1:    r.dots = 6'b000011; // b
                5'd2:    r.dots = 6'b001001; // c
                5'd3:    r.dots = 6'b011001; // d
                5'd4:    r.dots = 6'b010001; // e
                5'd5:    r.dots = 6'b001011; // f
                5'd6:    r.dots = 6'b011011; // g
                5'd7:    r.dots = 6'b010011; // h
                5'd8:    r.dots = 6'b001010; // i
                5'd9:    r.dots = 6'b011010; // j
                5'd10:   r.dots = 6'b000101; // k
                5'd11:   r.dots = 6'b000111; // l
                5'd12:   r.dots = 6'b001101; // m
                5'd13:   r.dots = 6'b011101; // n
                5'd14:   r.dots = 6'b010101; // o
                5'd15:   r.dots = 6'b001111; // p
                5'd16:   r.dots = 6'b011111; // q
                5'd17:   r.dots = 6'b010111; // r
                5'd18:   r.dots = 6'b001110; // s
                5'd19:   r.dots = 6'b011110; // t
                5'd20:   r.dots = 6'b100101; // u
                5'd21:   r.dots = 6'b100111; // v
                5'd22:   r.dots = 6'b111010; // w
                5'd23:   r.dots = 6'b101101; // x
                5'd24:   r.dots = 6'b111101; // y
                5'd25:   r.dots = 6'b110101; // z
                default: r.dots = 6'b000000;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    // DEPTH is a power of two, so the pointers wrap on their own
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/braille_cell_driver.sv
// Queues character codes, converts them to 6-dot Braille cells and shifts each
// into an external 74HC595-style latch: show for a dwell time, blank for a gap.
module braille_cell_driver
    import braille_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4,
    parameter int DWELL_CYC  = 100_000_000,
    parameter int GAP_CYC    = 20_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_valid,
    input  logic [7:0]  i_alpha,
    output logic        o_full,
    output logic        o_busy,
    output logic        o_ovf,
    output logic        o_err,
    output logic [5:0]  o_dots,
    output logic        sr_clk,
    output logic        sr_data,
    output logic        sr_latch
);

    // One down-counter serves the bit period, the latch pulse, dwell and gap
    localparam int BIT_CYC = 2 * CLK_DIV;
    localparam int MAX_DG  = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_DG > BIT_CYC) ? MAX_DG : BIT_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam int BW      = $clog2(FRAME_W);

    localparam logic [TW-1:0] BIT_LOAD   = TW'(BIT_CYC - 1);
    localparam logic [TW-1:0] HALF       = TW'(CLK_DIV);
    localparam logic [TW-1:0] LATCH_LOAD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYC - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYC - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_W - 1);

    state_t             state;
    state_t             nxt_state;
    frame_kind_t        kind;
    frame_kind_t        nxt_kind;
    logic [TW-1:0]      timer;
    logic [TW-1:0]      nxt_timer;
    logic [BW-1:0]      bit_cnt;
    logic [BW-1:0]      nxt_bit;
    logic [FRAME_W-1:0] frame_p0;
    logic [FRAME_W-1:0] nxt_frame;
    logic [DOTS_W-1:0]  dots_p0;
    logic [DOTS_W-1:0]  nxt_dots;
    logic               ld_dots;
    logic               pop;
    logic               started;

    logic [7:0]         fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;
    lookup_t            lk;

    sync_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (i_valid),
        .wr_data (i_alpha),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign lk     = alpha_to_dots(fifo_rd_data);
    assign o_full = fifo_full;
    assign o_ovf  = i_valid & fifo_full & ~pop;
    assign o_err  = (state == ST_LOAD) & ~lk.valid;
    // started keeps o_busy at 0 while reset is held even though the FSM sits in CLEAR
    assign o_busy = started & ((state != ST_IDLE) | ~fifo_empty);

    // Next-state, timer, shifter and display decisions
    always_comb begin
        nxt_state = state;
        nxt_kind  = kind;
        nxt_timer = timer;
        nxt_bit   = bit_cnt;
        nxt_frame = frame_p0;
        nxt_dots  = o_dots;
        ld_dots   = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_CLEAR: begin
                nxt_state = ST_SHIFT;
                nxt_kind  = FK_CLEAR;
                nxt_frame = '0;
                nxt_timer = BIT_LOAD;
                nxt_bit   = BIT_LAST;
            end
            ST_IDLE: begin
                if (!fifo_empty) nxt_state = ST_LOAD;
            end
            ST_LOAD: begin
                pop       = 1'b1;
                ld_dots   = 1'b1;
                nxt_state = ST_SHIFT;
                nxt_kind  = FK_CHAR;
                nxt_frame = {{(FRAME_W-DOTS_W){1'b0}}, lk.dots};
                nxt_timer = BIT_LOAD;
                nxt_bit   = BIT_LAST;
            end
            ST_SHIFT: begin
                if (timer != '0) begin
                    nxt_timer = timer - 1'b1;
                end else if (bit_cnt != '0) begin
                    nxt_bit   = bit_cnt - 1'b1;
                    nxt_timer = BIT_LOAD;
                    nxt_frame = {frame_p0[FRAME_W-2:0], 1'b0};
                end else begin
                    nxt_state = ST_LATCH;
                    nxt_timer = LATCH_LOAD;
                end
            end
            ST_LATCH: begin
                if (timer != '0) begin
                    nxt_timer = timer - 1'b1;
                end else begin
                    nxt_dots = (kind == FK_CHAR) ? dots_p0 : '0;
                    case (kind)
                        FK_CHAR: begin
                            nxt_state = ST_DWELL;
                            nxt_timer = DWELL_LOAD;
                        end
                        FK_GAP: begin
                            nxt_state = ST_GAP;
                            nxt_timer = GAP_LOAD;
                        end
                        default: nxt_state = ST_IDLE;
                    endcase
                end
            end
            ST_DWELL: begin
                if (timer != '0) begin
                    nxt_timer = timer - 1'b1;
                end else begin
                    nxt_state = ST_SHIFT;
                    nxt_kind  = FK_GAP;
                    nxt_frame = '0;
                    nxt_timer = BIT_LOAD;
                    nxt_bit   = BIT_LAST;
                end
            end
            ST_GAP: begin
                if (timer != '0) nxt_timer = timer - 1'b1;
                else             nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_CLEAR;
        endcase
    end

    // State register plus registered serial and display outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_CLEAR;
            kind     <= FK_CLEAR;
            timer    <= '0;
            bit_cnt  <= '0;
            started  <= 1'b0;
            o_dots   <= '0;
            sr_clk   <= 1'b0;
            sr_data  <= 1'b0;
            sr_latch <= 1'b0;
        end else begin
            state    <= nxt_state;
            kind     <= nxt_kind;
            timer    <= nxt_timer;
            bit_cnt  <= nxt_bit;
            started  <= 1'b1;
            o_dots   <= nxt_dots;
            // Low half of each bit while the timer is in its upper half; data moves on the fall
            sr_clk   <= (nxt_state == ST_SHIFT) & (nxt_timer < HALF);
            sr_data  <= (nxt_state == ST_SHIFT) & nxt_frame[FRAME_W-1];
            sr_latch <= (nxt_state == ST_LATCH);
        end
    end

    // Frame shifter and held pattern: pure data, qualified by the FSM
    always_ff @(posedge clk) begin
        frame_p0 <= nxt_frame;
        if (ld_dots) dots_p0 <= lk.dots;
    end

endmodule

// File: tb/tb_braille_cell_driver.sv
// Scoreboard bench for braille_cell_driver: serial frames are decoded from
// sr_clk/sr_data/sr_latch and compared in order against expected frames.
module tb_braille_cell_driver;

    localparam int K      = 2;
    localparam int D      = 50;
    localparam int G      = 20;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 2 * (16 * K + K) + D + G + 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_valid;
    logic [7:0] i_alpha;
    logic       o_full, o_busy, o_ovf, o_err;
    logic [5:0] o_dots;
    logic       sr_clk, sr_data, sr_latch;

    braille_cell_driver #(
        .FIFO_DEPTH (DEPTH),
        .CLK_DIV    (K),
        .DWELL_CYC  (D),
        .GAP_CYC    (G)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_valid  (i_valid),
        .i_alpha  (i_alpha),
        .o_full   (o_full),
        .o_busy   (o_busy),
        .o_ovf    (o_ovf),
        .o_err    (o_err),
        .o_dots   (o_dots),
        .sr_clk   (sr_clk),
        .sr_data  (sr_data),
        .sr_latch (sr_latch)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // {is_character, 8-bit frame}
    logic [8:0] exp_q [$];

    // Braille dot numbers for a..z
    string braille_cells [26] = '{"1", "12", "14", "145", "15", "124", "1245", "125", "24", "245",
                                  "13", "123", "134", "1345", "135", "1234", "12345", "1235", "234",
                                  "2345", "136", "1236", "2456", "1346", "13456", "1356"};

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] model_dots(input logic [7:0] code);
        logic [5:0] p;
        int         idx;
        string      s;
        p   = '0;
        idx = -1;
        if (code >= 8'h41 && code <= 8'h5A) idx = int'(code) - 'h41;
        if (code >= 8'h61 && code <= 8'h7A) idx = int'(code) - 'h61;
        if (idx >= 0) begin
            s = braille_cells[idx];
            for (int i = 0; i < s.len(); i++) p[int'(s[i]) - 49] = 1'b1;
        end
        return p;
    endfunction

    task automatic send(input logic [7:0] code, input logic exp_ovf);
        i_valid = 1'b1;
        i_alpha = code;
        #1;
        chk("ovf", 32'(o_ovf), 32'(exp_ovf));
        if (!exp_ovf) begin
            exp_q.push_back({1'b1, 2'b00, model_dots(code)});
            exp_q.push_back(9'h000);
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        int cnt;
        reset_n = 1'b0;
        exp_q.delete();
        exp_q.push_back(9'h000);
        #1;
        chk("rst_outputs", 32'({o_full, o_busy, o_ovf, o_err, o_dots, sr_clk, sr_data, sr_latch}), 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) chk("busy_after_rst", 32'(o_busy), 1);
        end while (o_busy && cnt < 200);
        chk("clear_len", cnt, 35);
        chk("full_after_rst", 32'(o_full), 0);
    endtask

    task automatic wait_sr_clk();
        for (int i = 0; i < 200 && !sr_clk; i++) begin
            @(posedge clk); #1;
        end
        chk("sr_clk_seen", 32'(sr_clk), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000 && o_busy; i++) begin
            @(posedge clk); #1;
        end
        chk("idle_reached", 32'(o_busy), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Serial monitor: decodes frames and checks them at the falling edge of sr_latch
    initial begin
        logic [7:0] shreg;
        logic [8:0] e;
        int         bits, lat_w, dcnt;
        logic       armed, prev_clk, prev_lat;
        shreg = '0; bits = 0; lat_w = 0; dcnt = 0;
        armed = 1'b0; prev_clk = 1'b0; prev_lat = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                shreg = '0; bits = 0; lat_w = 0; dcnt = 0;
                armed = 1'b0; prev_clk = 1'b0; prev_lat = 1'b0;
            end else begin
                if (armed) dcnt++;
                if (sr_clk && !prev_clk) begin
                    shreg = {shreg[6:0], sr_data};
                    bits++;
                    if (armed) begin
                        chk("dwell_len", dcnt, D + K);
                        armed = 1'b0;
                    end
                end
                if (sr_latch) lat_w++;
                if (!sr_latch && prev_lat) begin
                    chk("frame_pending", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("frame_bits", 32'(shreg), 32'(e[7:0]));
                        chk("dots_shown", 32'(o_dots), 32'(e[5:0]));
                        chk("sr_clk_pulses", bits, 8);
                        chk("latch_len", lat_w, K);
                        armed = e[8];
                        dcnt  = 0;
                    end
                    bits  = 0;
                    lat_w = 0;
                end
                prev_clk = sr_clk;
                prev_lat = sr_latch;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset_n = 1'b1;
        i_valid = 1'b0;
        i_alpha = 8'h00;
        #2;
        do_reset();
        wait_idle();

        // 'A' with latency from strobe to first sr_clk rise
        send(8'h41, 1'b0);
        cnt = 1;
        while (!sr_clk && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, 3 + K);
        chk("busy_in_shift", 32'(o_busy), 1);
        wait_idle();

        // 'C' (no error pulse in its LOAD) and 'z'
        send(8'h43, 1'b0);
        @(posedge clk); #1;
        chk("err_valid_letter", 32'(o_err), 0);
        wait_idle();
        send(8'h7A, 1'b0);
        wait_idle();

        // Invalid code followed by a queued letter
        send(8'h35, 1'b0);
        chk("err_idle", 32'(o_err), 0);
        send(8'h45, 1'b0);
        chk("err_load", 32'(o_err), 1);
        @(posedge clk); #1;
        chk("err_after", 32'(o_err), 0);
        wait_idle();

        // Burst of five while the FSM is busy: four queued, fifth dropped
        send(8'h67, 1'b0);
        wait_sr_clk();
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        send(8'h44, 1'b0);
        chk("full_after_four", 32'(o_full), 1);
        send(8'h45, 1'b1);
        chk("full_after_drop", 32'(o_full), 1);
        wait_idle();

        // Reset in the middle of shifting 'B'; nothing queued survives
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        wait_sr_clk();
        repeat (4) @(posedge clk);
        #1;
        do_reset();
        wait_idle();

        // Full queue plus a write in the LOAD cycle
        send(8'h68, 1'b0);
        send(8'h69, 1'b0);
        send(8'h6A, 1'b0);
        send(8'h6B, 1'b0);
        send(8'h6C, 1'b0);
        chk("full_before_load", 32'(o_full), 1);
        repeat (PERIOD + 2 - 5) @(posedge clk);
        #1;
        chk("full_in_load", 32'(o_full), 1);
        send(8'h6D, 1'b0);
        chk("full_after_pop_push", 32'(o_full), 1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
